message_packer: RTL and testbench
=================================

# message_packer

Upstream feeder for the SHA-256 core: collects message bytes from the UART receiver, applies SHA-256 padding for single-block messages of 1–55 bytes, and streams the resulting 512-bit block to the core as 16 big-endian 32-bit words on consecutive cycles. It sits between the UART RX byte stream and the core's `MP_dv_in` / `message_in` port pair. It holds off the next message until the core reports that the current hash has been sent.

## Interface
- `DATA_WIDTH`, 32, output word width; only 32 is supported.
- `MAX_BYTES`, 55, maximum message length that fits one padded block; fixed.
- `clk`  in  1  single clock.
- `rst`  in  1  reset; one clock, reset is synchronous and active-high.
- `rx_dv_in`  in  1  byte valid from UART RX; one byte per asserted cycle.
- `rx_byte_in`  in  8  message byte.
- `rx_last_in`  in  1  qualified by `rx_dv_in`; the byte is the final byte of the message.
- `core_done_in`  in  1  one-cycle pulse from the core: hash transmission finished.
- `MP_dv_out`  out  1  word valid to the core; high for exactly 16 contiguous cycles per block.
- `message_out`  out  32  block word; words W0..W15 in order.
- `busy_out`  out  1  high in PAD, EMIT and WAIT; the byte source must hold off.
- `err_out`  out  1  one-cycle pulse for each dropped byte.

## Operation
- States: IDLE, COLLECT, PAD, EMIT, WAIT.
- Storage: 16×32 buffer, cleared on reset and on WAIT→IDLE. 6-bit byte count L.
- Byte i is written to word i/4, lane bits [31-8*(i%4) -: 8]. Byte order is big-endian.
- IDLE: on `rx_dv_in`, store the byte at index 0 and set L=1.
  - If `rx_last_in` is also high, go to PAD; otherwise go to COLLECT.
- COLLECT: each valid byte is stored at index L and L increments.
  - If `rx_last_in` is high, go to PAD.
- Overflow: a valid byte arriving with L=55 is dropped and `err_out` pulses.
  - If `rx_last_in` is high on that byte, go to PAD with L=55.
  - Otherwise remain in COLLECT.
- PAD (1 cycle):
  - Write 0x80 at byte index L.
  - Bytes L+1..55 stay zero.
  - W14 = 0.
  - W15 = L*8, zero-extended; maximum value 440 (0x1B8).
- EMIT: 16 cycles. `MP_dv_out`=1 and `message_out`=W[k] for k=0..15. Then go to WAIT.
- WAIT: on `core_done_in`, clear the buffer, set L=0, go to IDLE.
- `core_done_in` outside WAIT is ignored.
- Any `rx_dv_in` in PAD, EMIT or WAIT: the byte is dropped and `err_out` pulses. The state is unaffected.
- Simultaneous `core_done_in` and `rx_dv_in` in WAIT: the byte is dropped with an `err_out` pulse, and the state moves to IDLE.

## Timing
- All outputs are registered.
- Reset values: `MP_dv_out`=0, `message_out`=0, `busy_out`=0, `err_out`=0, state IDLE, L=0, buffer all zero.
- Last byte accepted at cycle t:
  - PAD at t+1.
  - `MP_dv_out` high from t+2 through t+17 (W0 at t+2, W15 at t+17).
  - WAIT from t+18.
- `message_out` = 0 whenever `MP_dv_out`=0.
- `busy_out` rises the cycle after the last byte is accepted. It falls the cycle after `core_done_in` is sampled in WAIT.
- Reset mid-operation (any state): on the next edge all outputs go to reset values and the partial message is discarded. No partial block is ever emitted.
- `err_out` is high in the cycle after the dropped byte is sampled.

## Test plan
- "abc" (0x61,0x62,0x63; last on 0x63) -> W0=0x61626380, W1..W14=0, W15=0x00000018. `MP_dv_out` is high for 16 consecutive cycles starting 2 cycles after the last byte.
- Single byte 0x61 with last -> W0=0x61800000, W15=0x00000008. The IDLE→PAD path is taken directly.
- 55 bytes of 0x41, last on byte 55 -> W0..W12=0x41414141, W13=0x41414180, W14=0, W15=0x000001B8.
- 56 bytes of 0x41, last on byte 56 -> `err_out` pulses once and the block is identical to the 55-byte case. 57 bytes without last -> 2 `err_out` pulses and the block stays in COLLECT.
- Byte sent during WAIT, then `core_done_in` -> `err_out` pulses and the byte is not stored. A following "abc" produces the correct block, with no stale data from the previous message.
- Assert `rst` at the 5th cycle of EMIT -> `MP_dv_out`=0 on the next edge. A subsequent "abc" yields the exact "abc" block.

Source files
------------

// File: rtl/message_packer_if.sv
// Byte-stream and block-word bundle between UART RX, message_packer and the SHA-256 core.
interface message_packer_if;
  logic        rx_dv_in;
  logic [7:0]  rx_byte_in;
  logic        rx_last_in;
  logic        core_done_in;
  logic        MP_dv_out;
  logic [31:0] message_out;
  logic        busy_out;
  logic        err_out;

  modport master (
    output rx_dv_in, rx_byte_in, rx_last_in, core_done_in,
    input  MP_dv_out, message_out, busy_out, err_out
  );

  modport slave (
    input  rx_dv_in, rx_byte_in, rx_last_in, core_done_in,
    output MP_dv_out, message_out, busy_out, err_out
  );
endinterface

// File: rtl/message_packer.sv
// Collects up to 55 message bytes, applies SHA-256 padding and
// streams the single 512-bit block as 16 big-endian words.
module message_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BYTES  = 55
) (
  input logic             clk,
  input logic             rst,
  message_packer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, COLLECT, PAD, EMIT, WAIT
  } state_t;

  state_t state, nstate;

  logic [DATA_WIDTH-1:0] mem [16];
  logic [DATA_WIDTH-1:0] w0_pad;
  logic [DATA_WIDTH-1:0] word_d;
  logic [5:0]            len;
  logic [3:0]            cnt;
  logic [4:0]            sh;
  logic                  full;
  logic                  hold;
  logic                  take;
  logic                  clr;
  logic                  dv_d;
  logic                  busy_d;
  logic                  err_d;

  assign full = (len == 6'(MAX_BYTES));
  assign hold = (state == PAD) || (state == EMIT) || (state == WAIT);
  assign take = bus.rx_dv_in &&
                ((state == IDLE) || ((state == COLLECT) && !full));
  assign clr  = (state == WAIT) && bus.core_done_in;
  // byte lane of index len inside its word, MSB lane first
  assign sh   = {~len[1:0], 3'b000};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (bus.rx_dv_in)
          nstate = bus.rx_last_in ? PAD : COLLECT;
      end
      COLLECT: begin
        if (bus.rx_dv_in && bus.rx_last_in)
          nstate = PAD;
      end
      PAD:  nstate = EMIT;
      EMIT: begin
        if (cnt == 4'd15) nstate = WAIT;
      end
      WAIT: begin
        if (bus.core_done_in) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // W0 leaves during PAD, before the 0x80 marker lands in mem
  always_comb begin
    w0_pad = mem[0];
    if (len[5:2] == 4'd0)
      w0_pad[sh +: 8] = 8'h80;
  end

  always_comb begin
    dv_d   = 1'b0;
    word_d = '0;
    if (state == PAD) begin
      dv_d   = 1'b1;
      word_d = w0_pad;
    end else if ((state == EMIT) && (cnt != 4'd15)) begin
      dv_d   = 1'b1;
      word_d = mem[cnt + 4'd1];
    end
    busy_d = (nstate == PAD) || (nstate == EMIT) ||
             (nstate == WAIT);
    err_d  = bus.rx_dv_in &&
             (hold || ((state == COLLECT) && full));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.MP_dv_out   <= 1'b0;
      bus.message_out <= '0;
      bus.busy_out    <= 1'b0;
      bus.err_out     <= 1'b0;
    end else begin
      bus.MP_dv_out   <= dv_d;
      bus.message_out <= word_d;
      bus.busy_out    <= busy_d;
      bus.err_out     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      len <= '0;
      cnt <= '0;
    end else begin
      if (take) begin
        mem[len[5:2]][sh +: 8] <= bus.rx_byte_in;
        len <= len + 6'd1;
      end
      if (state == PAD) begin
        mem[len[5:2]][sh +: 8] <= 8'h80;
        mem[14] <= '0;
        mem[15] <= {{(DATA_WIDTH-9){1'b0}}, len, 3'b000};
        cnt     <= '0;
      end
      if (state == EMIT) cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_message_packer.sv
// Directed bench for message_packer: padding of short, max-length
// and overflowing messages, drops while busy, reset during EMIT.
module tb_message_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   errs  = 0;
  int   e0;

  logic [31:0] blk_abc [16];
  logic [31:0] blk_a   [16];
  logic [31:0] blk_55  [16];

  message_packer_if bus ();

  message_packer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && bus.err_out) errs++;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    bus.rx_dv_in   = 1'b1;
    bus.rx_byte_in = b;
    bus.rx_last_in = last;
    step();
    bus.rx_dv_in   = 1'b0;
    bus.rx_last_in = 1'b0;
  endtask

  task automatic send_n(input int n, input logic [7:0] b,
                        input logic last);
    for (int i = 0; i < n; i++)
      send(b, last && (i == n - 1));
  endtask

  // called right after the last byte edge (PAD cycle)
  task automatic expect_block(input string tag,
                              input logic [31:0] exp [16]);
    check({tag, " busy_pad"}, 32'(bus.busy_out), 32'd1);
    check({tag, " dv_pad"}, 32'(bus.MP_dv_out), 32'd0);
    for (int k = 0; k < 16; k++) begin
      step();
      check($sformatf("%s dv%0d", tag, k),
            32'(bus.MP_dv_out), 32'd1);
      check($sformatf("%s w%0d", tag, k),
            bus.message_out, exp[k]);
    end
    step();
    check({tag, " dv_end"}, 32'(bus.MP_dv_out), 32'd0);
    check({tag, " msg_end"}, bus.message_out, 32'd0);
    check({tag, " busy_wait"}, 32'(bus.busy_out), 32'd1);
  endtask

  task automatic done();
    bus.core_done_in = 1'b1;
    step();
    bus.core_done_in = 1'b0;
    check("busy_after_done", 32'(bus.busy_out), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      blk_abc[k] = 32'h0;
      blk_a[k]   = 32'h0;
      blk_55[k]  = (k < 13) ? 32'h41414141 : 32'h0;
    end
    blk_abc[0]  = 32'h61626380;
    blk_abc[15] = 32'h00000018;
    blk_a[0]    = 32'h61800000;
    blk_a[15]   = 32'h00000008;
    blk_55[13]  = 32'h41414180;
    blk_55[15]  = 32'h000001b8;

    bus.rx_dv_in     = 1'b0;
    bus.rx_byte_in   = 8'h00;
    bus.rx_last_in   = 1'b0;
    bus.core_done_in = 1'b0;
    step();
    step();
    check("rst_dv", 32'(bus.MP_dv_out), 32'd0);
    check("rst_msg", bus.message_out, 32'd0);
    check("rst_busy", 32'(bus.busy_out), 32'd0);
    check("rst_err", 32'(bus.err_out), 32'd0);
    rst = 1'b0;
    step();

    // "abc"
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    check("busy_collect", 32'(bus.busy_out), 32'd0);
    send(8'h63, 1'b1);
    expect_block("abc", blk_abc);
    done();

    // single byte, IDLE straight to PAD
    send(8'h61, 1'b1);
    expect_block("one", blk_a);
    done();

    // 55 bytes, exactly full
    e0 = errs;
    send_n(55, 8'h41, 1'b1);
    expect_block("b55", blk_55);
    check("b55_err", 32'(errs - e0), 32'd0);
    done();

    // 56 bytes: last one dropped
    e0 = errs;
    send_n(55, 8'h41, 1'b0);
    send(8'h42, 1'b1);
    check("b56_errpulse", 32'(bus.err_out), 32'd1);
    expect_block("b56", blk_55);
    check("b56_err", 32'(errs - e0), 32'd1);
    done();

    // 57 bytes without last: stays in COLLECT
    e0 = errs;
    send_n(57, 8'h41, 1'b0);
    step();
    check("b57_err", 32'(errs - e0), 32'd2);
    check("b57_busy", 32'(bus.busy_out), 32'd0);
    check("b57_dv", 32'(bus.MP_dv_out), 32'd0);
    send(8'h43, 1'b1);
    expect_block("b57", blk_55);
    check("b57_err_total", 32'(errs - e0), 32'd3);
    done();

    // bytes during WAIT, one together with core_done
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    send(8'h63, 1'b1);
    expect_block("abc2", blk_abc);
    e0 = errs;
    send(8'h55, 1'b0);
    check("wait_busy", 32'(bus.busy_out), 32'd1);
    bus.core_done_in = 1'b1;
    send(8'h77, 1'b1);
    bus.core_done_in = 1'b0;
    check("wait_done_busy", 32'(bus.busy_out), 32'd0);
    step();
    check("wait_err", 32'(errs - e0), 32'd2);
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    send(8'h63, 1'b1);
    expect_block("abc3", blk_abc);
    done();

    // reset on the 5th EMIT cycle
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    send(8'h63, 1'b1);
    for (int i = 0; i < 5; i++) step();
    check("emit5_dv", 32'(bus.MP_dv_out), 32'd1);
    check("emit5_w", bus.message_out, 32'd0);
    rst = 1'b1;
    step();
    check("mid_rst_dv", 32'(bus.MP_dv_out), 32'd0);
    check("mid_rst_msg", bus.message_out, 32'd0);
    check("mid_rst_busy", 32'(bus.busy_out), 32'd0);
    rst = 1'b0;
    step();
    check("post_rst_dv", 32'(bus.MP_dv_out), 32'd0);
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    send(8'h63, 1'b1);
    expect_block("abc4", blk_abc);
    done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
